mulred_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 25-bit modular multiply/reduce datapath (Q = 33292289). It accepts operand pairs from two requesters, for example the NTT butterfly and the pointwise-multiply engine. For each accepted pair it registers the 50-bit product and drives the external 3-cycle reduction unit. A tag pipeline routes each reduced result back to its requester's response FIFO. Credit-based admission guarantees the non-stallable reducer never overflows a response FIFO.

---
 rtl/mulred_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mulred_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mulred_arbiter.sv
// mulred_arbiter: two-requester front end for the shared modular multiply/reduce
// datapath. Round-robin picks one operand pair per cycle and registers the full
// product for the external reducer. A tag pipeline mirrors the reducer so each
// reduced value lands in its requester's response FIFO. Credits reserve FIFO
// space before issue, because the reducer cannot be stalled.

// Per-requester response channel: admission credits plus the response FIFO.
module mulred_rsp_chan #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept_i,     // operand pair granted this cycle
    input  logic          wr_en_i,      // reduced result for this requester
    input  logic [DW-1:0] wr_data_i,
    input  logic          pop_ready_i,  // consumer takes the head
    output logic          credit_ok_o,  // a FIFO slot is still unreserved
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_data_o,
    output logic          ovf_o         // write attempted into a full FIFO
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [AW:0]                  wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH-1:0][DW-1:0] mem_q;
    logic                         empty, full, push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && pop_ready_i;
    assign push  = wr_en_i && !full;
    assign ovf_o = wr_en_i && full;

    assign credit_ok_o = (cnt_q != '0);
    assign rsp_valid_o = !empty;
    assign rsp_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Credit next-state: accept consumes a slot, pop returns one, both cancel.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept_i, pop})
            2'b10:   cnt_d = cnt_q - CNT_ONE;
            2'b01:   cnt_d = cnt_q + CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit counter and FIFO storage; simultaneous push and pop both happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= CW'(FIFO_DEPTH);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end
endmodule

module mulred_arbiter #(
    parameter int Q          = 33292289,
    parameter int FIFO_DEPTH = 4,
    parameter int RED_LAT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [24:0] req0_a,
    input  logic [24:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [24:0] req1_a,
    input  logic [24:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [24:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [24:0] rsp1_data,
    output logic        red_en,
    output logic [49:0] red_din,
    input  logic [24:0] red_dout,
    input  logic        red_flag,
    output logic        busy,
    output logic        err
);
    localparam int DW = $clog2(Q);
    // Stage 0 is the product register; the reducer adds its own input sample
    // edge plus RED_LAT edges, so the tag tail sits RED_LAT+1 stages later.
    localparam int TAIL = RED_LAT + 1;

    logic [1:0]          valid, elig, gnt, credit_ok, rsp_valid, rsp_ready, wr_en, ovf;
    logic [1:0][DW-1:0]  rsp_data;
    logic [DW-1:0]       a_sel, b_sel;
    logic                last_q;          // 1: requester 1 was granted last
    logic [TAIL:0]       vld_pipe_q;
    logic [TAIL:0]       id_pipe_q;
    logic [49:0]         red_din_q;
    logic                err_q;
    logic                tail_ok;

    assign valid     = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign elig      = valid & credit_ok;

    // Round-robin: a lone eligible requester wins; a tie goes to the one not
    // granted last. Nothing is granted while in reset.
    always_comb begin
        gnt    = '0;
        gnt[0] = !rst && elig[0] && (!elig[1] || last_q);
        gnt[1] = !rst && elig[1] && (!elig[0] || !last_q);
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign a_sel = gnt[1] ? req1_a : req0_a;
    assign b_sel = gnt[1] ? req1_b : req0_b;

    // Last-grant pointer moves only when something is granted.
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|gnt)
            last_q <= gnt[1];
    end

    // Product register feeds the reducer; it holds its value between accepts.
    always_ff @(posedge clk) begin
        if (rst)
            red_din_q <= '0;
        else if (|gnt)
            red_din_q <= 50'(a_sel) * 50'(b_sel);
    end

    // Tag pipeline shadows the reducer: {valid, requester id} per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[TAIL-1:0], |gnt};
            id_pipe_q  <= {id_pipe_q[TAIL-1:0], gnt[1]};
        end
    end

    assign red_en  = vld_pipe_q[0];
    assign red_din = red_din_q;

    // A result is only trusted when the reducer's flag agrees with the tag.
    assign tail_ok = vld_pipe_q[TAIL] && red_flag;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_chan
            assign wr_en[i] = tail_ok && (id_pipe_q[TAIL] == 1'(i));
            mulred_rsp_chan #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .DW         (DW)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .accept_i    (gnt[i]),
                .wr_en_i     (wr_en[i]),
                .wr_data_i   (red_dout),
                .pop_ready_i (rsp_ready[i]),
                .credit_ok_o (credit_ok[i]),
                .rsp_valid_o (rsp_valid[i]),
                .rsp_data_o  (rsp_data[i]),
                .ovf_o       (ovf[i])
            );
        end
    endgenerate

    // Sticky error: tag/flag disagreement or a write into a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if ((vld_pipe_q[TAIL] != red_flag) || (|ovf))
            err_q <= 1'b1;
    end

    assign err        = err_q;
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];
    assign busy       = (|vld_pipe_q) || (|rsp_valid);
endmodule

// File: tb/tb_mulred_arbiter.sv
// Bench for mulred_arbiter: behavioural 3-stage reducer, directed stimulus,
// and a scoreboard of expected responses per requester checked on every pop.
module tb_mulred_arbiter;
    typedef longint unsigned u64_t;
    localparam u64_t QL = 64'd33292289;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [24:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [24:0] rsp0_data, rsp1_data;
    logic        red_en, red_flag, busy, err;
    logic [49:0] red_din;
    logic [24:0] red_dout;
    logic        inj;

    int tests = 0;
    int fails = 0;
    u64_t q0[$];
    u64_t q1[$];

    always #5 clk = ~clk;

    mulred_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .red_en(red_en), .red_din(red_din), .red_dout(red_dout), .red_flag(red_flag),
        .busy(busy), .err(err)
    );

    // Reducer model: samples en/Din on the edge after red_en rises, output
    // appears three edges later; shares rst with the DUT.
    logic [3:0]       m_v;
    logic [3:0][24:0] m_d;
    always @(posedge clk) begin
        if (rst) begin
            m_v <= '0;
            m_d <= '0;
        end else begin
            m_v <= {m_v[2:0], red_en};
            m_d <= {m_d[2:0], 25'(u64_t'(red_din) % QL)};
        end
    end
    assign red_flag = m_v[3] | inj;
    assign red_dout = m_d[3];

    function automatic u64_t mred(input logic [24:0] a, input logic [24:0] b);
        return (u64_t'(a) * u64_t'(b)) % QL;
    endfunction

    task automatic chk(input string nm, input u64_t act, input u64_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) q0.push_back(mred(req0_a, req0_b));
            if (req1_valid && req1_ready) q1.push_back(mred(req1_a, req1_b));
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("sb0_unexpected", 1, 0);
                else chk("sb0_data", u64_t'(rsp0_data), q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
                else chk("sb1_data", u64_t'(rsp1_data), q1.pop_front());
            end
        end
    end

    // One operation end to end; starts and ends just after a rising edge.
    task automatic do_op(input int id, input int a, input int b, input int exp);
        bit got;
        int lat;
        got = 0;
        if (id == 0) begin req0_a = a[24:0]; req0_b = b[24:0]; req0_valid = 1; end
        else         begin req1_a = a[24:0]; req1_b = b[24:0]; req1_valid = 1; end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("op_accept", got, 1);
        lat = 0;
        while (!((id == 0) ? rsp0_valid : rsp1_valid) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("op_latency", lat, 5);
        chk("op_data", (id == 0) ? rsp0_data : rsp1_data, exp);
        if (id == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    // Hold req0 as driven for n cycles, counting accepts and bumping operands.
    task automatic cyc_count(input int n, output int acc);
        bit g;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); g = req0_ready;
            @(posedge clk); #1;
            if (g) begin acc++; req0_a = req0_a + 25'd1; end
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 60) begin @(posedge clk); #1; n++; end
        chk(nm, busy, 0);
    endtask

    initial begin
        int acc, seen;
        int seq[8];
        bit g0, g1;
        rst = 1; inj = 0;
        req0_valid = 1; req1_valid = 1;
        req0_a = 25'd1; req0_b = 25'd1; req1_a = 25'd1; req1_b = 25'd1;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_red_en", red_en, 0);
        chk("rst_red_din", red_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 0; req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;

        // Single op, then busy must drop after the pop.
        do_op(0, 3, 5, 15);
        chk("single_busy_after_pop", busy, 0);
        chk("single_rsp_empty", rsp0_valid, 0);

        // Modular wrap cases on requester 1.
        do_op(1, 1 << 24, 2, 262143);
        do_op(1, 33292288, 33292288, 1);

        // Tie: alternate grants, requester 0 first.
        rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 25'd100; req0_b = 25'd200; req1_a = 25'd300; req1_b = 25'd400;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); g0 = req0_ready; g1 = req1_ready;
            @(posedge clk); #1;
            seq[i] = (g0 && !g1) ? 0 : (g1 && !g0) ? 1 : -1;
            if (g0) begin req0_a = req0_a + 25'd11; req0_b = req0_b + 25'd3; end
            if (g1) begin req1_a = req1_a + 25'd17; req1_b = req1_b + 25'd5; end
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 8; i++) chk($sformatf("tie_grant%0d", i), u64_t'(seq[i]), u64_t'(i % 2));
        wait_idle("tie_drain");
        chk("tie_sb_empty", q0.size() + q1.size(), 0);
        rsp0_ready = 0; rsp1_ready = 0;

        // Back-pressure: credits stop issue after FIFO_DEPTH accepts.
        req0_a = 25'd50; req0_b = 25'd60; req0_valid = 1;
        cyc_count(20, acc);
        chk("bp_accepts", acc, 4);
        chk("bp_err", err, 0);
        req0_valid = 0; rsp0_ready = 1;
        @(posedge clk); #1;
        rsp0_ready = 0; req0_valid = 1;
        cyc_count(15, acc);
        chk("bp_after_pop", acc, 1);
        req0_valid = 0; rsp0_ready = 1;
        @(posedge clk); #1;
        // One credit free: accept and pop together must leave it free.
        req0_valid = 1; rsp0_ready = 1;
        @(negedge clk);
        chk("bp_same_cycle_acc", req0_ready, 1);
        chk("bp_same_cycle_pop", rsp0_valid, 1);
        @(posedge clk); #1;
        req0_a = req0_a + 25'd1; rsp0_ready = 0;
        cyc_count(15, acc);
        chk("bp_steady_credit", acc, 1);
        chk("bp_no_err", err, 0);
        req0_valid = 0; rsp0_ready = 1;
        wait_idle("bp_drain");
        chk("bp_sb_empty", q0.size(), 0);
        rsp0_ready = 0;

        // Reset with three ops in flight.
        req0_a = 25'd1000; req0_b = 25'd3; req0_valid = 1;
        cyc_count(3, acc);
        chk("mid_accepts", acc, 3);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_ready", req0_ready, 0);
        @(posedge clk); #1;
        chk("mid_red_en", red_en, 0);
        chk("mid_red_din", red_din, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rsp0_valid", rsp0_valid, 0);
        chk("mid_rsp0_data", rsp0_data, 0);
        rst = 0; req0_valid = 0;
        q0.delete(); q1.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp0_valid || rsp1_valid) seen++;
        end
        chk("mid_no_stale_rsp", seen, 0);
        do_op(0, 7, 9, 63);

        // Spurious reducer flag with an empty tag pipeline.
        inj = 1;
        @(posedge clk); #1;
        inj = 0;
        chk("err_set", err, 1);
        repeat (5) @(posedge clk); #1;
        chk("err_sticky", err, 1);
        chk("err_no_write0", rsp0_valid, 0);
        chk("err_no_write1", rsp1_valid, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("err_cleared", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
